stream_serializer: RTL and testbench
====================================

Name: stream_serializer

Overview:
Parametrised successor to the fixed-size serializer. Converts a frame of NUM_WORDS words (WORD_SIZE bits each) into a stream of CHUNK_SIZE-bit chunks. Uses valid/ready handshakes on both sides, a two-slot input buffer for gap-free back-to-back frames, and selectable chunk and word ordering, including bit-reversed order for FFT output unscrambling. It sits between the FFT core's parallel result bus and the narrow output port.

Parameters:
NUM_WORDS, 8, words per frame; power of 2, >=2
WORD_SIZE, 32, bits per word (complex: {real16, imag16})
CHUNK_SIZE, 16, bits per output chunk; must divide WORD_SIZE exactly
MSB_CHUNK_FIRST, 1, 1: emit the upper chunk of each word first; 0: emit the lower chunk first
BIT_REVERSE, 0, 1: emit words in bit-reversed index order; 0: emit in ascending order (word 0 first)
Derived: CPW = WORD_SIZE/CHUNK_SIZE; FRAME_CHUNKS = NUM_WORDS*CPW; word i = in_data[i*WORD_SIZE +: WORD_SIZE]

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  synchronous active-low reset
in_valid  in  1  frame on in_data is valid
in_ready  out  1  block can accept a frame this cycle
in_data  in  NUM_WORDS*WORD_SIZE  parallel frame
out_valid  out  1  out_data holds a valid chunk
out_ready  in  1  downstream accepts the chunk
out_data  out  CHUNK_SIZE  current chunk
out_last  out  1  current chunk is the last of its frame
out_word_idx  out  $clog2(NUM_WORDS)  source word index of the current chunk (after reordering)
frame_done  out  1  one-cycle pulse, registered, the cycle after the last chunk is accepted
busy  out  1  at least one frame buffered or in flight

Behaviour:
- Reset (reset_n low at posedge): both slots empty, read/write pointers 0, chunk and word counters 0, out_valid=0, out_data=0, out_last=0, out_word_idx=0, frame_done=0, busy=0. Reset mid-frame discards all buffered data and no frame_done is emitted. in_ready is 0 while reset_n is low.
- Input handshake: a frame is accepted when in_valid and in_ready are both high at a posedge. The frame is stored in the write slot, and that slot's full flag is set.
- in_ready = !(slot0_full && slot1_full), driven only from registers. There is no combinational path from out_ready to in_ready.
- State machine, 2 states:
  - IDLE: out_valid=0. On the cycle after any slot becomes full, go to STREAM with word counter w=0 and chunk counter c=0.
  - STREAM: out_valid=1 and the output is driven from the read slot.
- Chunk selection:
  - word = BIT_REVERSE ? bitrev(w) : w.
  - MSB_CHUNK_FIRST=1: bits [word*WORD_SIZE + WORD_SIZE-1 - c*CHUNK_SIZE -: CHUNK_SIZE].
  - MSB_CHUNK_FIRST=0: bits [word*WORD_SIZE + c*CHUNK_SIZE +: CHUNK_SIZE].
- out_data, out_word_idx and out_last are registered. They hold stable while out_valid && !out_ready (AXI-style stall).
- Advance on each out_valid && out_ready:
  - c increments, wrapping at CPW; on wrap, w increments.
  - out_last=1 when w==NUM_WORDS-1 and c==CPW-1.
- On acceptance of the last chunk:
  - Clear the read slot's full flag and toggle the read pointer.
  - If the other slot is full, stay in STREAM: the next frame's chunk 0 is presented the very next cycle (zero bubbles). Otherwise go to IDLE.
- Simultaneous accept of a new frame and release of a slot in the same cycle is legal. Occupancy stays consistent, and in_ready does not glitch low.
- Latency: a frame accepted at edge N into an empty block presents chunk 0 with out_valid=1 after edge N+1. Throughput is 1 chunk/cycle with out_ready held high.
- frame_done=1 for exactly one cycle after the edge that accepted out_last. busy = any slot full || out_valid.

Test Plan:
- Defaults, words k = {real=k, imag=0x100+k}, out_ready=1 -> 16 chunks: 0x0000,0x0100,0x0001,0x0101,...,0x0007,0x0107; out_last only on chunk 16; frame_done one cycle after.
- BIT_REVERSE=1, same frame -> word order 0,4,2,6,1,5,3,7; out_word_idx matches; first chunks 0x0000,0x0100,0x0004,0x0104.
- Two frames offered back-to-back -> in_ready stays 1 for both; a third frame is held off (in_ready=0) until the first frame's last chunk is accepted; 32 consecutive valid chunks with no gap.
- out_ready toggled 1,0,0,1 pattern -> out_data/out_word_idx/out_last stable during stalls; no chunk lost or duplicated (scoreboard).
- MSB_CHUNK_FIRST=0, CHUNK_SIZE=8, word0=0xAABBCCDD -> chunks 0xDD,0xCC,0xBB,0xAA.
- reset_n low for 1 cycle at chunk 5 of frame with second frame buffered -> all outputs 0 next cycle, no frame_done, in_ready=1 after release, a new frame restarts at chunk 0.

Source files
------------

// File: rtl/stream_serializer.sv
// rtl/stream_serializer.sv - frame-to-chunk serializer with two-slot input buffer
module stream_serializer #(
    parameter int NUM_WORDS       = 8,
    parameter int WORD_SIZE       = 32,
    parameter int CHUNK_SIZE      = 16,
    parameter bit MSB_CHUNK_FIRST = 1'b1,
    parameter bit BIT_REVERSE     = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_WORDS*WORD_SIZE-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHUNK_SIZE-1:0]           out_data,
    output logic                            out_last,
    output logic [$clog2(NUM_WORDS)-1:0]    out_word_idx,
    output logic                            frame_done,
    output logic                            busy
);

    localparam int CPW = WORD_SIZE / CHUNK_SIZE;
    localparam int WW  = $clog2(NUM_WORDS);
    localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int FW  = NUM_WORDS * WORD_SIZE;
    localparam logic [WW-1:0] W_LAST = WW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPW - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    state_t          state_next;
    logic [FW-1:0]   slot_data [2];
    logic [1:0]      slot_full;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [WW-1:0]   w;
    logic [CW-1:0]   c;

    logic            in_fire;
    logic            out_fire;
    logic            load;
    logic            release_slot;
    logic            src_slot;
    logic [WW-1:0]   w_next;
    logic [CW-1:0]   c_next;
    logic [WW-1:0]   word_sel;
    logic [CW-1:0]   chunk_sel;
    logic [31:0]     shamt;
    logic [CHUNK_SIZE-1:0] chunk_next;

    function automatic logic [WW-1:0] bitrev(input logic [WW-1:0] x);
        logic [WW-1:0] r;
        for (int i = 0; i < WW; i++) begin
            r[i] = x[WW-1-i];
        end
        return r;
    endfunction

    // in_ready depends only on slot flags, so out_ready never reaches it combinationally
    assign in_ready  = reset_n && !(slot_full[0] && slot_full[1]);
    assign out_valid = (state == STREAM);
    assign busy      = slot_full[0] || slot_full[1] || out_valid;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (slot_full[rd_ptr]) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (out_fire && out_last && !slot_full[~rd_ptr]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load         = 1'b0;
        release_slot = 1'b0;
        src_slot     = rd_ptr;
        w_next       = w;
        c_next       = c;
        case (state)
            IDLE: begin
                if (slot_full[rd_ptr]) begin
                    load   = 1'b1;
                    w_next = '0;
                    c_next = '0;
                end
            end
            STREAM: begin
                if (out_fire) begin
                    if (out_last) begin
                        // Hand straight over to the other slot when it is already waiting
                        release_slot = 1'b1;
                        src_slot     = ~rd_ptr;
                        load         = slot_full[~rd_ptr];
                        w_next       = '0;
                        c_next       = '0;
                    end else if (c == C_LAST) begin
                        load   = 1'b1;
                        w_next = w + 1'b1;
                        c_next = '0;
                    end else begin
                        load   = 1'b1;
                        c_next = c + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        word_sel   = BIT_REVERSE ? bitrev(w_next) : w_next;
        chunk_sel  = MSB_CHUNK_FIRST ? (C_LAST - c_next) : c_next;
        shamt      = 32'(word_sel) * 32'(WORD_SIZE) + 32'(chunk_sel) * 32'(CHUNK_SIZE);
        chunk_next = CHUNK_SIZE'(slot_data[src_slot] >> shamt);
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            slot_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_full    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            w            <= '0;
            c            <= '0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_word_idx <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= out_fire && out_last;
            if (in_fire) begin
                slot_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
            if (release_slot) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
            end
            if (load) begin
                w            <= w_next;
                c            <= c_next;
                out_data     <= chunk_next;
                out_word_idx <= word_sel;
                out_last     <= (w_next == W_LAST) && (c_next == C_LAST);
            end else if (release_slot) begin
                w        <= '0;
                c        <= '0;
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// tb/tb_stream_serializer.sv - randomized scoreboard bench for stream_serializer
module tb_stream_serializer;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         out_ready;
    logic [255:0] in_data;
    logic [2:0]   in_valid;
    logic [2:0]   ir, ov, ol, fd, bz;
    logic [15:0]  od0, od1;
    logic [7:0]   od2;
    logic [2:0]   oi0, oi1, oi2;

    stream_serializer dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
        .out_last(ol[0]), .out_word_idx(oi0), .frame_done(fd[0]), .busy(bz[0])
    );

    stream_serializer #(.BIT_REVERSE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
        .out_last(ol[1]), .out_word_idx(oi1), .frame_done(fd[1]), .busy(bz[1])
    );

    stream_serializer #(.CHUNK_SIZE(8), .MSB_CHUNK_FIRST(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2),
        .out_last(ol[2]), .out_word_idx(oi2), .frame_done(fd[2]), .busy(bz[2])
    );

    int total = 0;
    int bad = 0;
    logic [1:0] sel = 2'd0;

    logic        m_valid, m_last, m_fd, m_busy, m_ready;
    logic [15:0] m_data;
    logic [2:0]  m_idx;

    always_comb begin
        m_valid = ov[sel];
        m_last  = ol[sel];
        m_fd    = fd[sel];
        m_busy  = bz[sel];
        m_ready = ir[sel];
        m_data  = (sel == 2'd0) ? od0 : (sel == 2'd1) ? od1 : {8'h00, od2};
        m_idx   = (sel == 2'd0) ? oi0 : (sel == 2'd1) ? oi1 : oi2;
    end

    logic [15:0] got_data [$];
    logic [2:0]  got_idx  [$];
    logic        got_last [$];
    int          got_cyc  [$];
    logic [15:0] ex_data  [$];
    logic [2:0]  ex_idx   [$];
    logic        ex_last  [$];

    int cyc = 0;
    int fd_cnt = 0;
    int fd_err = 0;
    int stall_err = 0;
    logic prev_last_acc = 1'b0;
    logic prev_stall = 1'b0;
    logic [15:0] p_data;
    logic [2:0]  p_idx;
    logic        p_last;

    // Observes the selected DUT mid-cycle: records accepted chunks and audits pulses and stalls
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (m_valid && out_ready) begin
                got_data.push_back(m_data);
                got_idx.push_back(m_idx);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            if (m_fd === 1'b1) fd_cnt++;
            if (m_fd !== prev_last_acc) fd_err++;
            if (prev_stall && (m_valid !== 1'b1 || m_data !== p_data || m_idx !== p_idx || m_last !== p_last))
                stall_err++;
        end
        prev_last_acc = reset_n && m_valid && out_ready && m_last;
        prev_stall    = reset_n && m_valid && !out_ready;
        p_data = m_data;
        p_idx  = m_idx;
        p_last = m_last;
    end

    function automatic logic [15:0] exp_chunk(input logic [255:0] f, input int k, input int cs,
                                              input bit msb, input bit br, output int widx);
        int cpw, wpos, c, sh;
        logic [31:0] word;
        cpw  = 32 / cs;
        wpos = k / cpw;
        c    = k % cpw;
        widx = br ? (((wpos & 1) << 2) | (wpos & 2) | ((wpos >> 2) & 1)) : wpos;
        word = f[widx*32 +: 32];
        sh   = msb ? (cpw - 1 - c) * cs : c * cs;
        return 16'((word >> sh) & ((32'd1 << cs) - 1));
    endfunction

    task automatic push_exp(input logic [255:0] f, input int cs, input bit msb, input bit br);
        int fc, wi;
        fc = 8 * (32 / cs);
        for (int k = 0; k < fc; k++) begin
            ex_data.push_back(exp_chunk(f, k, cs, msb, br, wi));
            ex_idx.push_back(3'(wi));
            ex_last.push_back(k == fc - 1);
        end
    endtask

    task automatic clear_sb();
        got_data.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
        ex_data.delete(); ex_idx.delete(); ex_last.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_chunks(input int n);
        int b = 0;
        while (got_data.size() < n && b < 500) begin
            tick();
            b++;
        end
    endtask

    task automatic send_frame(input int d, input logic [255:0] f);
        int b = 0;
        in_valid[d] = 1'b1;
        in_data = f;
        while (!ir[d] && b < 500) begin
            tick();
            b++;
        end
        tick();
        in_valid[d] = 1'b0;
    endtask

    function automatic logic [255:0] rand_frame();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [255:0] k_frame();
        logic [255:0] f;
        for (int k = 0; k < 8; k++) f[k*32 +: 32] = {16'(k), 16'(16'h0100 + k)};
        return f;
    endfunction

    task automatic test_reset();
        sel = 2'd0;
        reset_n = 1'b0;
        out_ready = 1'b0;
        in_valid = '0;
        in_data = '0;
        tick(); tick();
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", m_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 16'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", m_data); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", m_last); end
        total++; if (m_idx !== 3'd0) begin bad++; $display("FAIL reset_word_idx: got %0d want 0", m_idx); end
        total++; if (m_fd !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", m_fd); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        reset_n = 1'b1;
        #1;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", m_ready); end
        tick();
    endtask

    task automatic test_single_frame();
        logic [255:0] f;
        int fd0;
        sel = 2'd0;
        clear_sb();
        out_ready = 1'b1;
        fd0 = fd_cnt;
        f = k_frame();
        push_exp(f, 16, 1'b1, 1'b0);
        send_frame(0, f);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got %b want 0", m_valid); end
        tick();
        total++; if (m_valid !== 1'b1 || m_data !== 16'h0000) begin
            bad++; $display("FAIL latency_chunk0: got valid=%b data=%h want valid=1 data=0000", m_valid, m_data); end
        wait_chunks(16);
        tick(); tick();
        total++; if (got_data.size() !== 16) begin bad++; $display("FAIL single_count: got %0d want 16", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL single_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], ex_idx[i], ex_last[i]);
            end
        end
        total++; if (fd_cnt - fd0 !== 1 || fd_err !== 0) begin
            bad++; $display("FAIL single_frame_done: got pulses=%0d err=%0d want 1/0", fd_cnt - fd0, fd_err); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", m_busy); end
    endtask

    task automatic test_bit_reverse();
        logic [2:0] order [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        logic [255:0] f;
        sel = 2'd1;
        clear_sb();
        out_ready = 1'b1;
        f = k_frame();
        push_exp(f, 16, 1'b1, 1'b1);
        send_frame(1, f);
        wait_chunks(16);
        tick();
        total++; if (got_data.size() !== 16) begin bad++; $display("FAIL bitrev_count: got %0d want 16", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_idx[i] !== order[i/2] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL bitrev_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], order[i/2], ex_last[i]);
            end
        end
        total++; if (got_data.size() >= 4 && got_data[2] !== 16'h0004) begin
            bad++; $display("FAIL bitrev_third: got %h want 0004", got_data[2]); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] fa, fb, fc;
        int b = 0;
        sel = 2'd0;
        clear_sb();
        out_ready = 1'b1;
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        push_exp(fa, 16, 1'b1, 1'b0);
        push_exp(fb, 16, 1'b1, 1'b0);
        push_exp(fc, 16, 1'b1, 1'b0);
        in_valid[0] = 1'b1;
        in_data = fa;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_a: got %b want 1", m_ready); end
        tick();
        in_data = fb;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_b: got %b want 1", m_ready); end
        tick();
        in_data = fc;
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL b2b_held_c: got %b want 0", m_ready); end
        while (!m_ready && b < 100) begin
            tick();
            b++;
        end
        total++; if (got_data.size() !== 16 || got_last[got_data.size()-1] !== 1'b1) begin
            bad++; $display("FAIL b2b_release_point: got chunks=%0d want 16 with last", got_data.size()); end
        tick();
        in_valid[0] = 1'b0;
        wait_chunks(48);
        tick(); tick();
        total++; if (got_data.size() !== 48) begin bad++; $display("FAIL b2b_count: got %0d want 48", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 48; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL b2b_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], ex_idx[i], ex_last[i]);
            end
        end
        total++; if (got_data.size() == 48 && got_cyc[47] - got_cyc[0] !== 47) begin
            bad++; $display("FAIL b2b_gapless: got span=%0d want 47", got_cyc[47] - got_cyc[0]); end
    endtask

    task automatic test_stall();
        logic [255:0] fa, fb;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int n = 0;
        sel = 2'd0;
        clear_sb();
        out_ready = 1'b0;
        fa = rand_frame(); fb = rand_frame();
        push_exp(fa, 16, 1'b1, 1'b0);
        push_exp(fb, 16, 1'b1, 1'b0);
        send_frame(0, fa);
        send_frame(0, fb);
        while (got_data.size() < 32 && n < 400) begin
            out_ready = pat[n % 4];
            tick();
            n++;
        end
        out_ready = 1'b1;
        tick(); tick();
        total++; if (got_data.size() !== 32) begin bad++; $display("FAIL stall_count: got %0d want 32", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 32; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL stall_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], ex_idx[i], ex_last[i]);
            end
        end
        total++; if (stall_err !== 0 || fd_err !== 0) begin
            bad++; $display("FAIL stall_hold: got stall_err=%0d fd_err=%0d want 0/0", stall_err, fd_err); end
    endtask

    task automatic test_lsb_chunks();
        logic [7:0] first [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        logic [255:0] f;
        sel = 2'd2;
        clear_sb();
        out_ready = 1'b1;
        f = rand_frame();
        f[31:0] = 32'hAABBCCDD;
        push_exp(f, 8, 1'b0, 1'b0);
        send_frame(2, f);
        wait_chunks(32);
        tick();
        total++; if (got_data.size() !== 32) begin bad++; $display("FAIL lsb_count: got %0d want 32", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            total++;
            if (got_data[i] !== {8'h00, first[i]}) begin
                bad++; $display("FAIL lsb_word0_chunk%0d: got %h want %h", i, got_data[i], first[i]); end
        end
        for (int i = 0; i < got_data.size() && i < 32; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL lsb_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], ex_idx[i], ex_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] fa, fb, fd_frame;
        int fdc, nch;
        sel = 2'd0;
        clear_sb();
        out_ready = 1'b1;
        fa = rand_frame(); fb = rand_frame(); fd_frame = rand_frame();
        send_frame(0, fa);
        send_frame(0, fb);
        wait_chunks(5);
        reset_n = 1'b0;
        #1;
        total++; if (m_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_low: got %b want 0", m_ready); end
        tick();
        reset_n = 1'b1;
        total++; if (m_valid !== 1'b0 || m_data !== 16'h0 || m_last !== 1'b0 || m_idx !== 3'd0 || m_fd !== 1'b0 || m_busy !== 1'b0) begin
            bad++; $display("FAIL midrst_outputs: got v=%b d=%h l=%b i=%0d fd=%b busy=%b want all 0",
                m_valid, m_data, m_last, m_idx, m_fd, m_busy); end
        #1;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after: got %b want 1", m_ready); end
        fdc = fd_cnt;
        nch = got_data.size();
        repeat (20) tick();
        total++; if (fd_cnt !== fdc || got_data.size() !== nch || m_busy !== 1'b0) begin
            bad++; $display("FAIL midrst_quiet: got pulses=%0d chunks=%0d busy=%b want 0/0/0",
                fd_cnt - fdc, got_data.size() - nch, m_busy); end
        clear_sb();
        push_exp(fd_frame, 16, 1'b1, 1'b0);
        send_frame(0, fd_frame);
        wait_chunks(16);
        tick(); tick();
        total++; if (got_data.size() !== 16) begin bad++; $display("FAIL midrst_count: got %0d want 16", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            total++;
            if (got_data[i] !== ex_data[i] || got_idx[i] !== ex_idx[i] || got_last[i] !== ex_last[i]) begin
                bad++; $display("FAIL midrst_chunk%0d: got %h/%0d/%b want %h/%0d/%b", i,
                    got_data[i], got_idx[i], got_last[i], ex_data[i], ex_idx[i], ex_last[i]);
            end
        end
        total++; if (fd_cnt - fdc !== 1 || fd_err !== 0) begin
            bad++; $display("FAIL midrst_frame_done: got pulses=%0d err=%0d want 1/0", fd_cnt - fdc, fd_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_reverse();
        test_back_to_back();
        test_stall();
        test_lsb_chunks();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
